// File: rtl/imem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_pkg : shared types for the instruction-fetch front end          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package imem_pkg;

  localparam int INSTRUCT_MEM_SIZE = 1024;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : circular buffer of fetched {pc, instr} entries          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t           r_mem [DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_fetch_ctrl : sequential instruction fetch with redirect/fault   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = INSTRUCT_MEM_SIZE,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic         r_fault;
  logic         w_pc_bad;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign imem_addr = r_pc;
  assign fault     = r_fault;
  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  // pc+3 wraps naturally; a wrapped result near zero is still misaligned.
  assign w_pc_bad = (r_pc[1:0] != 2'b00) || ((r_pc + 64'd3) >= 64'(MEM_SIZE));
  assign w_pop    = out_valid && out_ready && !redirect_valid;
  assign w_push   = (r_state == FETCH) && !redirect_valid && !w_pc_bad
                    && (!w_full || w_pop);
  assign w_entry  = '{pc: r_pc, instr: imem_instr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_state <= FETCH;
      r_pc    <= redirect_pc;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_pc_bad) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (w_push) begin
            r_pc <= r_pc + 64'd4;
          end
        end
        default: begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_data(w_entry),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 The block SHALL have parameter MEM_SIZE, default 1024, the instruction-memory size in bytes (power of two, >4).
REQ-003 The block SHALL have parameter DEPTH, default 2, the fetch-buffer entry count (power of two, >=2).
REQ-004 clk  in  1  sole clock, all state updates on posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  64  byte address driven to the combinational instruction memory.
REQ-007 imem_instr  in  32  instruction returned combinationally for imem_addr.
REQ-008 redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
REQ-009 redirect_pc  in  64  redirect target, valid with redirect_valid.
REQ-010 out_valid  out  1  buffer head holds a fetched instruction.
REQ-011 out_ready  in  1  decode accepts the head this cycle.
REQ-012 out_instr  out  32  head instruction.
REQ-013 out_pc  out  64  head instruction's address.
REQ-014 fault  out  1  fetch stopped on a misaligned or out-of-bounds PC.

Function
REQ-015 The block SHALL hold a 64-bit pc register and drive imem_addr = pc at all times.
REQ-016 The block SHALL implement states FETCH and FAULT.
REQ-017 In FETCH, the block SHALL treat pc as bad when pc[1:0] != 0 or pc+3 >= MEM_SIZE.
REQ-018 In FETCH with pc good and no redirect, the block SHALL push {pc, imem_instr} and set pc <= pc+4 when the buffer is not full or a pop occurs in the same cycle.
REQ-019 In FETCH with the buffer full and no pop, the block SHALL hold pc and push nothing.
REQ-020 In FETCH with pc bad and no redirect, the block SHALL push nothing, hold pc, and enter FAULT.
REQ-021 A pop SHALL occur when out_valid && out_ready; out_instr/out_pc SHALL be the head entry, registered, never combinational from imem_instr.
REQ-022 The push-to-out_valid latency SHALL be one cycle (entry visible after the edge that writes it).
REQ-023 On redirect_valid in any state, the block SHALL flush all buffer entries, discard any pop and push that cycle, set pc <= redirect_pc, and enter FETCH.
REQ-024 FAULT SHALL assert fault=1, perform no pushes, and still let decode drain remaining entries.
REQ-025 The buffer SHALL be a circular FIFO with DEPTH entries, pointer wrap at DEPTH, and an occupancy count of width clog2(DEPTH)+1; out_valid = (count != 0).
REQ-026 pc+4 SHALL wrap modulo 2^64 without special handling; the bound check in REQ-017 catches the result.

Reset
REQ-027 When reset_n is asserted, state SHALL be FETCH, pc = RESET_PC, buffer empty, out_valid = 0, fault = 0, out_instr = 0, out_pc = 0, asynchronously and mid-operation.
REQ-028 The first push SHALL occur on the first posedge with reset_n high.

Structure
REQ-029 Shared package imem_pkg SHALL hold INSTRUCT_MEM_SIZE, enum fetch_state_t {FETCH, FAULT}, and struct fetch_entry_t {pc[63:0], instr[31:0]}.
REQ-030 The FIFO SHALL be the sub-module fetch_fifo (push, pop, flush, full, empty, head), reused by the pipeline.

Verification
REQ-031 The bench SHALL cover reset release with RESET_PC=0, mem[0..2]=A,B,C, and out_ready=1: out_pc 0,4,8 on consecutive cycles with instructions A,B,C.
REQ-032 The bench SHALL cover out_ready=0 for 5 cycles: count saturates at 2, pc holds at 8, then release yields 0,4,8 in order with no loss or duplication.
REQ-033 The bench SHALL cover redirect_valid with redirect_pc=0x40 while the buffer is full: next cycle out_valid=0, then out_pc=0x40.
REQ-034 The bench SHALL cover sequential fetch to pc=1020 followed by pc=1024: entry 1020 delivered, then fault=1 with no further pushes; redirect to 0 clears fault.
REQ-035 The bench SHALL cover redirect_pc=0x6 (misaligned): next cycle fault=1 and out_valid=0.
REQ-036 The bench SHALL cover reset_n asserted mid-stream: out_valid and fault drop immediately, and fetch restarts at RESET_PC.
